// File: rtl/fifo_pktreader.sv
// fifo_pktreader: drains an asynchronous-read FIFO into a valid/ready stream as one packet of a commanded length.
// Optional abort support (i_abort / o_aborted) is compiled in when FIFO_PKTREADER_ABORT_EN is defined.
module fifo_pktreader #(
  parameter int BW    = 32,
  parameter int LGLEN = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LGLEN-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  input  logic             i_fifo_empty,
  input  logic [BW-1:0]    i_fifo_data,
  output logic             o_fifo_rd,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BW-1:0]    o_data,
  output logic             o_last
`ifdef FIFO_PKTREADER_ABORT_EN
  ,
  input  logic             i_abort,
  output logic             o_aborted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [LGLEN-1:0] LEN_ONE = LGLEN'(1);

  state_t           state_q, state_d;
  logic [LGLEN-1:0] remain_q, remain_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [BW-1:0]    data_q, data_d;
  logic             fifo_rd;
  logic             accept;
  logic             abort_req;

`ifdef FIFO_PKTREADER_ABORT_EN
  logic aborted_q, aborted_d;

  // An abort only has meaning while a packet is in flight.
  assign abort_req = i_abort && (state_q != S_IDLE);
  assign aborted_d = abort_req;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign o_aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  assign accept = valid_q && i_ready;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    valid_d  = valid_q;
    last_d   = last_q;
    data_d   = data_q;
    done_d   = 1'b0;
    fifo_rd  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            remain_d = i_len;
            state_d  = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        // Refill the output stage whenever it is empty or being emptied this cycle.
        fifo_rd = !i_fifo_empty && (!valid_q || i_ready);
        if (fifo_rd) begin
          data_d   = i_fifo_data;
          valid_d  = 1'b1;
          last_d   = (remain_q == LEN_ONE);
          remain_d = remain_q - LEN_ONE;
          if (remain_q == LEN_ONE) begin
            state_d = S_DRAIN;
          end
        end else if (accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end

      S_DRAIN: begin
        if (accept && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything: drop the beat, leave unfetched words in the FIFO.
    if (abort_req) begin
      fifo_rd  = 1'b0;
      data_d   = data_q;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      remain_d = '0;
      state_d  = S_IDLE;
      done_d   = 1'b1;
    end

    if (i_reset) begin
      fifo_rd = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      data_q   <= data_d;
    end
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = done_q;
  assign o_fifo_rd = fifo_rd;
  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_last    = last_q;

endmodule

// File: tb/tb_fifo_pktreader.sv
// Directed bench for fifo_pktreader with a small array-backed FIFO model on the read side.
module tb_fifo_pktreader;
  localparam int BW    = 32;
  localparam int LGLEN = 16;

  logic             clk = 1'b0;
  logic             i_reset, i_start, i_ready;
  logic [LGLEN-1:0] i_len;
  logic             o_busy, o_done, o_fifo_rd, o_valid, o_last;
  logic [BW-1:0]    o_data;
  logic             fifo_empty;
  logic [BW-1:0]    fifo_data;
  logic             abort_now;
`ifdef FIFO_PKTREADER_ABORT_EN
  logic             i_abort;
  logic             o_aborted;
  assign abort_now = i_abort;
`else
  assign abort_now = 1'b0;
`endif

  always #5 clk = ~clk;

  fifo_pktreader #(.BW(BW), .LGLEN(LGLEN)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_last       (o_last)
`ifdef FIFO_PKTREADER_ABORT_EN
    ,
    .i_abort      (i_abort),
    .o_aborted    (o_aborted)
`endif
  );

  // FIFO model: asynchronous head word, pop on the rising edge when read.
  logic [BW-1:0] mem [0:255];
  logic [7:0]    rd_ptr = 8'd0;
  logic [7:0]    wr_ptr = 8'd0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  always @(posedge clk) begin
    if (o_fifo_rd) rd_ptr <= rd_ptr + 8'd1;
  end

  // Stream monitor, sampled mid-cycle.
  logic [BW-1:0] beat_data [0:255];
  logic          beat_last [0:255];
  int            beat_n = 0, rd_n = 0, done_n = 0, stall_err = 0, empty_rd_err = 0;
  logic          hold_chk = 1'b0, hold_last = 1'b0;
  logic [BW-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (o_valid && i_ready) begin
      beat_data[beat_n[7:0]] <= o_data;
      beat_last[beat_n[7:0]] <= o_last;
      beat_n <= beat_n + 1;
    end
    if (o_fifo_rd) rd_n <= rd_n + 1;
    if (o_fifo_rd && fifo_empty) empty_rd_err <= empty_rd_err + 1;
    if (o_done) done_n <= done_n + 1;
    if (hold_chk && (o_valid !== 1'b1 || o_data !== hold_data || o_last !== hold_last))
      stall_err <= stall_err + 1;
    hold_chk  <= o_valid && !i_ready && !i_reset && !abort_now;
    hold_data <= o_data;
    hold_last <= o_last;
  end

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [BW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== '0) begin bad++;
      $display("FAIL rst_stream got v=%0b l=%0b d=%0h exp v=0 l=0 d=0", o_valid, o_last, o_data); end
    total++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_fifo_rd !== 1'b0) begin bad++;
      $display("FAIL rst_ctrl got busy=%0b done=%0b rd=%0b exp 0 0 0", o_busy, o_done, o_fifo_rd); end
    tick(); i_reset = 1'b0;
    @(negedge clk);
    total++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin bad++;
      $display("FAIL rst_release got busy=%0b v=%0b exp 0 0", o_busy, o_valid); end
    tick();
  endtask

  task automatic test_nominal();
    int b0, r0, d0;
    b0 = beat_n; r0 = rd_n; d0 = done_n;
    for (int k = 0; k < 8; k++) push(32'h100 + k);
    i_ready = 1'b1; i_len = 16'd8; i_start = 1'b1;
    @(negedge clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL nom_busy_c0 got=%0b exp=0", o_busy); end
    tick(); i_start = 1'b0;
    @(negedge clk);
    total++; if (o_busy !== 1'b1 || o_fifo_rd !== 1'b1 || o_valid !== 1'b0) begin bad++;
      $display("FAIL nom_c1 got busy=%0b rd=%0b v=%0b exp 1 1 0", o_busy, o_fifo_rd, o_valid); end
    for (int k = 0; k < 8; k++) begin
      tick(); @(negedge clk);
      total++; if (o_valid !== 1'b1 || o_data !== (32'h100 + k) || o_last !== (k == 7) || o_done !== 1'b0) begin bad++;
        $display("FAIL nom_beat%0d got v=%0b d=%0h l=%0b done=%0b exp v=1 d=%0h l=%0b done=0",
                 k, o_valid, o_data, o_last, o_done, 32'h100 + k, (k == 7)); end
    end
    tick(); @(negedge clk);
    total++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin bad++;
      $display("FAIL nom_done got done=%0b busy=%0b v=%0b exp 1 0 0", o_done, o_busy, o_valid); end
    tick(); @(negedge clk);
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL nom_done_pulse got=%0b exp=0", o_done); end
    tick();
    total++; if (beat_n - b0 != 8 || rd_n - r0 != 8 || done_n - d0 != 1) begin bad++;
      $display("FAIL nom_counts got beats=%0d rds=%0d dones=%0d exp 8 8 1", beat_n - b0, rd_n - r0, done_n - d0); end
  endtask

  task automatic test_backpressure();
    int b0, r0;
    logic [BW-1:0] ed [0:6];
    logic          el [0:6];
    ed = '{32'h100, 32'h101, 32'h101, 32'h102, 32'h102, 32'h103, 32'h103};
    el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    b0 = beat_n; r0 = rd_n;
    for (int k = 0; k < 4; k++) push(32'h100 + k);
    i_ready = 1'b1; i_len = 16'd4; i_start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick(); i_start = 1'b0; i_ready = (c % 2 == 0);
      @(negedge clk);
      if (c >= 2 && c <= 8) begin
        total++; if (o_valid !== 1'b1 || o_data !== ed[c-2] || o_last !== el[c-2]) begin bad++;
          $display("FAIL bp_c%0d got v=%0b d=%0h l=%0b exp v=1 d=%0h l=%0b", c, o_valid, o_data, o_last, ed[c-2], el[c-2]); end
      end
      if (c == 9) begin
        total++; if (o_done !== 1'b1 || o_valid !== 1'b0) begin bad++;
          $display("FAIL bp_done got done=%0b v=%0b exp 1 0", o_done, o_valid); end
      end
    end
    tick(); i_ready = 1'b1;
    total++; if (beat_n - b0 != 4 || rd_n - r0 != 4) begin bad++;
      $display("FAIL bp_counts got beats=%0d rds=%0d exp 4 4", beat_n - b0, rd_n - r0); end
    for (int k = 0; k < 4; k++) begin
      total++; if (beat_data[b0 + k] !== (32'h100 + k)) begin bad++;
        $display("FAIL bp_order%0d got=%0h exp=%0h", k, beat_data[b0 + k], 32'h100 + k); end
    end
  endtask

  task automatic test_underflow();
    int b0, r0, nl;
    b0 = beat_n; r0 = rd_n;
    for (int k = 0; k < 3; k++) push(32'h200 + k);
    i_ready = 1'b1; i_len = 16'd6; i_start = 1'b1;
    tick(); i_start = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    total++; if (o_valid !== 1'b1 || o_data !== 32'h202 || o_fifo_rd !== 1'b0) begin bad++;
      $display("FAIL uf_c4 got v=%0b d=%0h rd=%0b exp v=1 d=202 rd=0", o_valid, o_data, o_fifo_rd); end
    for (int c = 5; c <= 9; c++) begin
      tick(); @(negedge clk);
      total++; if (o_valid !== 1'b0 || o_fifo_rd !== 1'b0 || o_busy !== 1'b1) begin bad++;
        $display("FAIL uf_gap_c%0d got v=%0b rd=%0b busy=%0b exp 0 0 1", c, o_valid, o_fifo_rd, o_busy); end
    end
    tick();
    for (int k = 3; k < 6; k++) push(32'h200 + k);
    for (int c = 0; c < 12; c++) tick();
    total++; if (beat_n - b0 != 6 || rd_n - r0 != 6) begin bad++;
      $display("FAIL uf_counts got beats=%0d rds=%0d exp 6 6", beat_n - b0, rd_n - r0); end
    nl = 0;
    for (int k = 0; k < 6; k++) begin
      if (beat_last[b0 + k]) nl++;
      total++; if (beat_data[b0 + k] !== (32'h200 + k)) begin bad++;
        $display("FAIL uf_order%0d got=%0h exp=%0h", k, beat_data[b0 + k], 32'h200 + k); end
    end
    total++; if (nl != 1 || beat_last[b0 + 5] !== 1'b1) begin bad++;
      $display("FAIL uf_last got lasts=%0d final=%0b exp 1 1", nl, beat_last[b0 + 5]); end
  endtask

  task automatic test_start_busy();
    int b0, r0, d0, nl;
    b0 = beat_n; r0 = rd_n; d0 = done_n;
    for (int k = 0; k < 8; k++) push(32'h400 + k);
    i_ready = 1'b1; i_len = 16'd8; i_start = 1'b1;
    tick(); i_start = 1'b0;
    tick(); tick();
    i_len = 16'd3; i_start = 1'b1;
    @(negedge clk);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL sb_busy got=%0b exp=1", o_busy); end
    tick(); i_start = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    total++; if (beat_n - b0 != 8 || rd_n - r0 != 8 || done_n - d0 != 1) begin bad++;
      $display("FAIL sb_counts got beats=%0d rds=%0d dones=%0d exp 8 8 1", beat_n - b0, rd_n - r0, done_n - d0); end
    nl = 0;
    for (int k = 0; k < 8; k++) if (beat_last[b0 + k]) nl++;
    total++; if (nl != 1 || beat_data[b0 + 7] !== 32'h407 || beat_last[b0 + 7] !== 1'b1) begin bad++;
      $display("FAIL sb_last got lasts=%0d d=%0h l=%0b exp 1 407 1", nl, beat_data[b0 + 7], beat_last[b0 + 7]); end
  endtask

  task automatic test_back_to_back();
    push(32'h600); push(32'h601);
    i_ready = 1'b1; i_len = 16'd1; i_start = 1'b1;
    tick(); i_start = 1'b0;
    @(negedge clk);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy1 got=%0b exp=1", o_busy); end
    tick(); @(negedge clk);
    total++; if (o_valid !== 1'b1 || o_data !== 32'h600 || o_last !== 1'b1) begin bad++;
      $display("FAIL b2b_beat1 got v=%0b d=%0h l=%0b exp 1 600 1", o_valid, o_data, o_last); end
    tick(); i_start = 1'b1; i_len = 16'd1;
    @(negedge clk);
    total++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin bad++;
      $display("FAIL b2b_done1 got done=%0b busy=%0b exp 1 0", o_done, o_busy); end
    tick(); i_start = 1'b0;
    @(negedge clk);
    total++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin bad++;
      $display("FAIL b2b_restart got busy=%0b done=%0b exp 1 0", o_busy, o_done); end
    tick(); @(negedge clk);
    total++; if (o_valid !== 1'b1 || o_data !== 32'h601 || o_last !== 1'b1) begin bad++;
      $display("FAIL b2b_beat2 got v=%0b d=%0h l=%0b exp 1 601 1", o_valid, o_data, o_last); end
    tick(); @(negedge clk);
    total++; if (o_done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%0b exp=1", o_done); end
    tick();
  endtask

  task automatic test_reset_mid();
    int b0, r0, d0;
    b0 = beat_n; r0 = rd_n; d0 = done_n;
    for (int k = 0; k < 8; k++) push(32'h500 + k);
    i_ready = 1'b1; i_len = 16'd8; i_start = 1'b1;
    tick(); i_start = 1'b0;
    tick(); tick(); tick();
    i_reset = 1'b1;
    @(negedge clk);
    total++; if (o_fifo_rd !== 1'b0 || o_data !== 32'h502) begin bad++;
      $display("FAIL rm_c4 got rd=%0b d=%0h exp rd=0 d=502", o_fifo_rd, o_data); end
    tick(); i_reset = 1'b0;
    @(negedge clk);
    total++; if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin bad++;
      $display("FAIL rm_outs got v=%0b l=%0b d=%0h busy=%0b done=%0b exp all 0", o_valid, o_last, o_data, o_busy, o_done); end
    for (int c = 0; c < 4; c++) tick();
    total++; if (done_n != d0 || rd_n - r0 != 3 || beat_n - b0 != 3 || (wr_ptr - rd_ptr) != 8'd5) begin bad++;
      $display("FAIL rm_counts got dones=%0d rds=%0d beats=%0d level=%0d exp 0 3 3 5",
               done_n - d0, rd_n - r0, beat_n - b0, wr_ptr - rd_ptr); end
  endtask

  task automatic test_zero_len();
    int r0, d0;
    r0 = rd_n; d0 = done_n;
    i_len = 16'd0; i_start = 1'b1;
    @(negedge clk);
    total++; if (o_fifo_rd !== 1'b0) begin bad++; $display("FAIL zl_rd_c0 got=%0b exp=0", o_fifo_rd); end
    tick(); i_start = 1'b0;
    @(negedge clk);
    total++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_fifo_rd !== 1'b0) begin bad++;
      $display("FAIL zl_c1 got done=%0b busy=%0b v=%0b rd=%0b exp 1 0 0 0", o_done, o_busy, o_valid, o_fifo_rd); end
    tick(); @(negedge clk);
    total++; if (o_done !== 1'b0 || o_valid !== 1'b0) begin bad++;
      $display("FAIL zl_c2 got done=%0b v=%0b exp 0 0", o_done, o_valid); end
    tick();
    total++; if (rd_n != r0 || done_n - d0 != 1 || (wr_ptr - rd_ptr) != 8'd5) begin bad++;
      $display("FAIL zl_counts got rds=%0d dones=%0d level=%0d exp 0 1 5", rd_n - r0, done_n - d0, wr_ptr - rd_ptr); end
  endtask

  task automatic test_drain_left(input logic [BW-1:0] first);
    int b0, d0;
    b0 = beat_n; d0 = done_n;
    i_ready = 1'b1; i_len = 16'd5; i_start = 1'b1;
    tick(); i_start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    total++; if (beat_n - b0 != 5 || done_n - d0 != 1 || wr_ptr != rd_ptr) begin bad++;
      $display("FAIL dl_counts got beats=%0d dones=%0d level=%0d exp 5 1 0", beat_n - b0, done_n - d0, wr_ptr - rd_ptr); end
    for (int k = 0; k < 5; k++) begin
      total++; if (beat_data[b0 + k] !== first + BW'(k) || beat_last[b0 + k] !== (k == 4)) begin bad++;
        $display("FAIL dl_beat%0d got d=%0h l=%0b exp d=%0h l=%0b", k, beat_data[b0 + k], beat_last[b0 + k], first + BW'(k), (k == 4)); end
    end
  endtask

`ifdef FIFO_PKTREADER_ABORT_EN
  task automatic test_abort();
    int r0;
    r0 = rd_n;
    for (int k = 0; k < 8; k++) push(32'h700 + k);
    i_ready = 1'b1; i_len = 16'd8; i_start = 1'b1;
    tick(); i_start = 1'b0;
    tick(); tick(); tick();
    i_abort = 1'b1;
    @(negedge clk);
    total++; if (o_fifo_rd !== 1'b0) begin bad++; $display("FAIL ab_rd got=%0b exp=0", o_fifo_rd); end
    tick(); i_abort = 1'b0;
    @(negedge clk);
    total++; if (o_done !== 1'b1 || o_aborted !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin bad++;
      $display("FAIL ab_c5 got done=%0b ab=%0b v=%0b busy=%0b exp 1 1 0 0", o_done, o_aborted, o_valid, o_busy); end
    tick(); @(negedge clk);
    total++; if (o_done !== 1'b0 || o_aborted !== 1'b0) begin bad++;
      $display("FAIL ab_c6 got done=%0b ab=%0b exp 0 0", o_done, o_aborted); end
    tick(); i_abort = 1'b1;
    tick(); i_abort = 1'b0;
    @(negedge clk);
    total++; if (o_done !== 1'b0 || o_aborted !== 1'b0) begin bad++;
      $display("FAIL ab_idle got done=%0b ab=%0b exp 0 0", o_done, o_aborted); end
    tick();
    total++; if (rd_n - r0 != 3 || (wr_ptr - rd_ptr) != 8'd5) begin bad++;
      $display("FAIL ab_counts got rds=%0d level=%0d exp 3 5", rd_n - r0, wr_ptr - rd_ptr); end
  endtask
`endif

  task automatic test_handshake_rules();
    total++; if (stall_err != 0) begin bad++; $display("FAIL hs_stall got=%0d exp=0", stall_err); end
    total++; if (empty_rd_err != 0) begin bad++; $display("FAIL hs_empty_rd got=%0d exp=0", empty_rd_err); end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_len = '0; i_ready = 1'b1;
`ifdef FIFO_PKTREADER_ABORT_EN
    i_abort = 1'b0;
`endif
    tick(); tick(); tick();
    test_reset();
    test_nominal();
    test_backpressure();
    test_underflow();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_zero_len();
    test_drain_left(32'h503);
`ifdef FIFO_PKTREADER_ABORT_EN
    test_abort();
    test_drain_left(32'h703);
`endif
    test_handshake_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_pktreader.md
# fifo_pktreader

Drains the read port of an asynchronous-read `sfifo` into a valid/ready stream as one packet of a commanded length. A single-cycle start command loads the packet length. The block then issues FIFO reads, marks the final beat with `o_last`, and pulses `o_done` once the final beat is accepted. It sits between the receive-data FIFO and downstream DMA/framing logic and sustains one word per clock when neither side stalls.

## Interface
- `BW`, 32, data width; must match the width of the attached FIFO.
- `LGLEN`, 16, width of the length command and of the internal word counter.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_start`  in  1  command strobe; honoured only while `!o_busy`.
- `i_len`  in  LGLEN  packet length in words; sampled when `i_start` is honoured.
- `o_busy`  out  1  high from the cycle after an accepted start until `o_done`.
- `o_done`  out  1  one-cycle completion pulse.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `i_fifo_data`  in  BW  FIFO head word; valid in the same cycle whenever `!i_fifo_empty`.
- `o_fifo_rd`  out  1  FIFO read strobe; combinational.
- `o_valid`  out  1  stream valid; registered.
- `i_ready`  in  1  stream ready.
- `o_data`  out  BW  stream data; registered.
- `o_last`  out  1  final beat of the packet; registered.
- `i_abort`  in  1  abort request; present only under `FIFO_PKTREADER_ABORT_EN`.
- `o_aborted`  out  1  high together with an `o_done` that ended an abort; present only under `FIFO_PKTREADER_ABORT_EN`.

## Operation
- States: IDLE, RUN, DRAIN.
- Counter `remain` (LGLEN bits) holds the number of words not yet fetched from the FIFO.
- IDLE:
  - `i_start && i_len!=0`: `remain<=i_len`, next state RUN.
  - `i_start && i_len==0`: no beats are emitted; `o_done` pulses on the next cycle; the state stays IDLE.
- Stage-load condition: `o_fifo_rd = (state==RUN) && !i_fifo_empty && (!o_valid || i_ready)`.
- When `o_fifo_rd` is high:
  - `o_data<=i_fifo_data`, `o_valid<=1`, `o_last<=(remain==1)`, `remain<=remain-1`.
  - If `remain==1`, next state DRAIN.
- When `o_valid && i_ready` and no stage load occurs: `o_valid<=0`, `o_last<=0`.
- DRAIN: holds until the beat with `o_last` is accepted (`o_valid && i_ready && o_last`). It then goes to IDLE, pulses `o_done`, and drops `o_busy`, all in the following cycle.
- Handshake rules:
  - `o_data` and `o_last` never change while `o_valid && !i_ready`.
  - `o_valid` never drops without acceptance, except on reset or abort.
  - No FIFO read occurs in IDLE or DRAIN.
- `i_start` while busy is ignored; `i_len` is not re-sampled.
- `i_len` uses the full LGLEN range, maximum `2^LGLEN-1`; the counter never wraps.
- Reset values: state IDLE, `remain=0`, `o_valid=0`, `o_last=0`, `o_data=0`, `o_busy=0`, `o_done=0`, `o_aborted=0`. `o_fifo_rd` is 0 during reset.
- Reset mid-packet: the packet is discarded with no `o_done`, and words left in the FIFO are not touched.

## Timing
- Start latency: `i_start` at cycle 0 → `o_busy` high and the first `o_fifo_rd` possible at cycle 1 → first `o_valid` at cycle 2.
- Throughput: one word per cycle while `!i_fifo_empty && i_ready`.
- FIFO empty for k cycles inserts k bubbles and no spurious beats.
- Completion: last beat accepted at cycle t → `o_done=1` and `o_busy=0` at t+1. A new `i_start` is honoured from t+1.
- A simultaneous read and output acceptance in the same cycle keeps `o_valid` high with the new word.

## Configuration
- `FIFO_PKTREADER_ABORT_EN` defined:
  - Adds `i_abort` and `o_aborted`.
  - `i_abort` in RUN or DRAIN forces `o_valid<=0`, `o_last<=0`, state IDLE, `o_fifo_rd=0` that cycle. `o_done` and `o_aborted` pulse next cycle.
  - Unfetched FIFO words remain in the FIFO.
  - `i_abort` in IDLE is ignored.
- Macro undefined: neither port exists and packets always run to completion.

## Test plan
- Nominal: FIFO preloaded with 0x100..0x107, `i_len=8`, `i_ready=1` → eight beats on cycles 2..9, `o_last` only on 0x107, `o_done` at cycle 10.
- Backpressure: `i_len=4` with `i_ready` toggling 1,0,1,0 → data 0x100..0x103 in order, each held stable while stalled, exactly 4 FIFO reads.
- Underflow: FIFO empty for 5 cycles mid-packet → `o_valid` low during the gap, no reads while empty, total beats equals `i_len`.
- Zero length: `i_start`, `i_len=0` → `o_done` next cycle, no `o_valid`, no `o_fifo_rd`.
- Start while busy: second `i_start` with `i_len=3` during an 8-word packet → ignored, exactly 8 beats, one `o_done`.
- Reset/abort: `i_reset` after 3 of 8 beats → all outputs reset, FIFO keeps 5 words. With `FIFO_PKTREADER_ABORT_EN`, `i_abort` at the same point → `o_done && o_aborted` next cycle, FIFO keeps 5 words.
